// File: rtl/common_lib_pseudo_uninvert_buf.sv
// common_lib_pseudo_uninvert_buf: ping-pong reorder buffer returning pseudo-inverted frames to natural order.
// Define COMMON_LIB_PSEUDO_UNINVERT_BUF_OUT_REG_EN to add a registered output slice (+1 cycle latency).
module common_lib_pseudo_uninvert_buf #(
    parameter int S      = 4,
    parameter int B      = 2,
    parameter int DATA_W = 32,
    localparam int B_W   = $clog2(B),
    localparam int S_W   = $clog2(S),
    localparam int N     = B ** S,
    localparam int A_W   = S * B_W
) (
    input  logic              clk,
    input  logic              s_rst_n,
    input  logic [DATA_W-1:0] in_data,
    input  logic [S_W-1:0]    in_step,
    input  logic              in_vld,
    output logic              in_rdy,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    output logic              out_vld,
    input  logic              out_rdy
);
    typedef enum logic [1:0] {ST_EMPTY, ST_FILLING, ST_FULL, ST_DRAINING} bank_st_t;

    bank_st_t          r_st [2];
    bank_st_t          w_st_nxt [2];
    logic [DATA_W-1:0] r_mem [2][N];
    logic              r_wr_bank, r_rd_bank, r_iss_done;
    logic [A_W-1:0]    r_wr_cnt, r_rd_cnt;
    logic [S_W-1:0]    r_step;
    logic [DATA_W-1:0] r_sk_data [2];
    logic              r_sk_last [2];
    logic              r_sk_wp, r_sk_rp;
    logic [1:0]        r_sk_cnt;
    logic [S_W-1:0]    w_step_in, w_step;
    logic [A_W-1:0]    w_waddr;
    logic              w_wr, w_iss, w_sk_vld, w_sk_rdy, w_sk_pop, w_acc_last;

    // Input position z holds natural index v; digit j of v comes from digit src of z.
    function automatic logic [A_W-1:0] f_uninvert(input logic [A_W-1:0] z, input int st);
        logic [A_W-1:0] v;
        int src;
        v = '0;
        for (int j = 0; j < S; j++) begin
            src = (j < S - st) ? j + st : S - 1 - j;
            v[j*B_W +: B_W] = z[src*B_W +: B_W];
        end
        return v;
    endfunction

    assign w_step_in  = (int'(in_step) >= S) ? '0 : in_step;
    assign w_step     = (r_wr_cnt == '0) ? w_step_in : r_step;
    assign w_waddr    = f_uninvert(r_wr_cnt, int'(w_step));
    assign in_rdy     = (r_st[r_wr_bank] == ST_EMPTY) || (r_st[r_wr_bank] == ST_FILLING);
    assign w_wr       = in_vld && in_rdy;
    assign w_sk_vld   = r_sk_cnt != 2'd0;
    assign w_sk_pop   = w_sk_vld && w_sk_rdy;
    // Reads are issued only when the skid can absorb the result next cycle.
    assign w_iss      = ((r_st[r_rd_bank] == ST_FULL) || (r_st[r_rd_bank] == ST_DRAINING && !r_iss_done))
                        && (r_sk_cnt != 2'd2 || w_sk_pop);
    assign w_acc_last = out_vld && out_rdy && out_last;

    always_comb begin
        w_st_nxt = r_st;
        if (w_wr)
            w_st_nxt[r_wr_bank] = (&r_wr_cnt) ? ST_FULL : ST_FILLING;
        if (r_st[r_rd_bank] == ST_FULL)
            w_st_nxt[r_rd_bank] = ST_DRAINING;
        if (w_acc_last)
            w_st_nxt[r_rd_bank] = ST_EMPTY;
    end

    always_ff @(posedge clk) begin
        if (w_wr)
            r_mem[r_wr_bank][w_waddr] <= in_data;
    end

    always_ff @(posedge clk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            r_st       <= '{ST_EMPTY, ST_EMPTY};
            r_wr_bank  <= 1'b0;
            r_rd_bank  <= 1'b0;
            r_iss_done <= 1'b0;
            r_wr_cnt   <= '0;
            r_rd_cnt   <= '0;
            r_step     <= '0;
            r_sk_data  <= '{'0, '0};
            r_sk_last  <= '{1'b0, 1'b0};
            r_sk_wp    <= 1'b0;
            r_sk_rp    <= 1'b0;
            r_sk_cnt   <= 2'd0;
        end else begin
            r_st <= w_st_nxt;
            if (w_wr) begin
                r_wr_cnt <= r_wr_cnt + 1'b1;
                if (r_wr_cnt == '0)
                    r_step <= w_step_in;
                if (&r_wr_cnt)
                    r_wr_bank <= !r_wr_bank;
            end
            if (w_iss) begin
                r_rd_cnt           <= r_rd_cnt + 1'b1;
                r_iss_done         <= &r_rd_cnt;
                r_sk_data[r_sk_wp] <= r_mem[r_rd_bank][r_rd_cnt];
                r_sk_last[r_sk_wp] <= &r_rd_cnt;
                r_sk_wp            <= !r_sk_wp;
            end
            if (w_sk_pop)
                r_sk_rp <= !r_sk_rp;
            if (w_acc_last) begin
                r_rd_bank  <= !r_rd_bank;
                r_iss_done <= 1'b0;
            end
            r_sk_cnt <= r_sk_cnt + {1'b0, w_iss} - {1'b0, w_sk_pop};
        end
    end

`ifdef COMMON_LIB_PSEUDO_UNINVERT_BUF_OUT_REG_EN
    logic              r_o_vld, r_o_last;
    logic [DATA_W-1:0] r_o_data;

    assign w_sk_rdy = !r_o_vld || out_rdy;

    always_ff @(posedge clk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            r_o_vld  <= 1'b0;
            r_o_last <= 1'b0;
            r_o_data <= '0;
        end else if (w_sk_rdy) begin
            r_o_vld  <= w_sk_vld;
            r_o_last <= w_sk_vld && r_sk_last[r_sk_rp];
            r_o_data <= r_sk_data[r_sk_rp];
        end
    end

    assign out_vld  = r_o_vld;
    assign out_last = r_o_last;
    assign out_data = r_o_data;
`else
    assign w_sk_rdy = out_rdy;
    assign out_vld  = w_sk_vld;
    assign out_last = w_sk_vld && r_sk_last[r_sk_rp];
    assign out_data = r_sk_data[r_sk_rp];
`endif
endmodule

// File: tb/tb_common_lib_pseudo_uninvert_buf.sv
// tb_common_lib_pseudo_uninvert_buf: directed checks of the reorder buffer with S=3, B=2.
module tb_common_lib_pseudo_uninvert_buf;
`ifdef COMMON_LIB_PSEUDO_UNINVERT_BUF_OUT_REG_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 2;
`endif

    logic        clk;
    logic        s_rst_n;
    logic [31:0] in_data;
    logic [1:0]  in_step;
    logic        in_vld;
    logic        in_rdy;
    logic [31:0] out_data;
    logic        out_last;
    logic        out_vld;
    logic        out_rdy;

    common_lib_pseudo_uninvert_buf #(.S(3), .B(2), .DATA_W(32)) dut (
        .clk      (clk),
        .s_rst_n  (s_rst_n),
        .in_data  (in_data),
        .in_step  (in_step),
        .in_vld   (in_vld),
        .in_rdy   (in_rdy),
        .out_data (out_data),
        .out_last (out_last),
        .out_vld  (out_vld),
        .out_rdy  (out_rdy)
    );

    // Natural-order output a carries input beat exp_tab[step][a].
    int exp_tab [3][8] = '{'{0, 1, 2, 3, 4, 5, 6, 7},
                           '{0, 2, 4, 6, 1, 3, 5, 7},
                           '{0, 4, 2, 6, 1, 5, 3, 7}};

    int          n_cmp = 0;
    int          n_err = 0;
    int          cyc = 0;
    int          t_acc = 0;
    int          rise_cyc = -1;
    int          acc_cnt = 0;
    int          stall_acc = -1;
    logic [31:0] q_data [$];
    logic        q_last [$];
    logic        prev_vld = 1'b0;
    logic        stalled = 1'b0;
    logic [31:0] hold_d = '0;
    logic        hold_l = 1'b0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (s_rst_n && stalled) begin
            n_cmp++;
            if (out_vld !== 1'b1 || out_data !== hold_d || out_last !== hold_l) begin
                n_err++;
                $display("FAIL stall_hold: got vld=%0b data=%0d last=%0b, want vld=1 data=%0d last=%0b",
                         out_vld, out_data, out_last, hold_d, hold_l);
            end
        end
        if (out_vld && !prev_vld)
            rise_cyc = cyc;
        if (out_vld && out_rdy) begin
            q_data.push_back(out_data);
            q_last.push_back(out_last);
        end
        stalled  = s_rst_n && out_vld && !out_rdy;
        hold_d   = out_data;
        hold_l   = out_last;
        prev_vld = out_vld;
    end

    task automatic drive_beat(input int d, input logic [1:0] st);
        int guard = 0;
        logic ok;
        in_vld  = 1'b1;
        in_data = d;
        in_step = st;
        do begin
            @(negedge clk);
            ok = in_rdy;
            if (!ok && stall_acc < 0)
                stall_acc = acc_cnt;
            t_acc = cyc;
            @(posedge clk);
            #1;
            guard++;
        end while (!ok && guard < 200);
        if (!ok) begin
            n_cmp++;
            n_err++;
            $display("FAIL in_rdy_timeout: beat data=%0d not accepted within 200 cycles", d);
        end else begin
            acc_cnt++;
        end
        in_vld = 1'b0;
    endtask

    task automatic send_frame(input logic [1:0] st, input int base, input logic [1:0] alt, input int nbeats);
        for (int k = 0; k < nbeats; k++)
            drive_beat(base + k, (k == 0) ? st : alt);
    endtask

    task automatic wait_q(input int n);
        int guard = 0;
        while (q_data.size() < n && guard < 400) begin
            @(negedge clk);
            guard++;
        end
        if (q_data.size() < n) begin
            n_cmp++;
            n_err++;
            $display("FAIL out_timeout: got %0d outputs, want %0d", q_data.size(), n);
        end
    endtask

    task automatic test_reset();
        s_rst_n = 1'b0;
        in_vld  = 1'b0;
        in_data = '0;
        in_step = '0;
        out_rdy = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++; if (in_rdy !== 1'b1) begin n_err++; $display("FAIL rst_in_rdy: got %0b want 1", in_rdy); end
        n_cmp++; if (out_vld !== 1'b0) begin n_err++; $display("FAIL rst_out_vld: got %0b want 0", out_vld); end
        n_cmp++; if (out_last !== 1'b0) begin n_err++; $display("FAIL rst_out_last: got %0b want 0", out_last); end
        n_cmp++; if (out_data !== 32'd0) begin n_err++; $display("FAIL rst_out_data: got %0d want 0", out_data); end
        @(negedge clk);
        s_rst_n = 1'b1;
    endtask

    task automatic test_perm(input int st);
        int t_last;
        logic [31:0] d;
        logic l;
        @(posedge clk);
        #1;
        out_rdy = 1'b1;
        q_data.delete();
        q_last.delete();
        send_frame(2'(st), 0, 2'(st), 8);
        t_last = t_acc;
        wait_q(8);
        n_cmp++;
        if (rise_cyc !== t_last + LAT) begin
            n_err++;
            $display("FAIL latency_step%0d: got first out_vld at %0d, want %0d", st, rise_cyc, t_last + LAT);
        end
        for (int a = 0; a < 8 && q_data.size() > 0; a++) begin
            d = q_data.pop_front();
            l = q_last.pop_front();
            n_cmp++;
            if (d !== 32'(exp_tab[st][a])) begin
                n_err++;
                $display("FAIL data_step%0d[%0d]: got %0d want %0d", st, a, d, exp_tab[st][a]);
            end
            n_cmp++;
            if (l !== (a == 7)) begin
                n_err++;
                $display("FAIL last_step%0d[%0d]: got %0b want %0b", st, a, l, a == 7);
            end
        end
    endtask

    task automatic test_back_to_back();
        int steps [3] = '{2, 1, 0};
        int bases [3] = '{100, 200, 300};
        logic [31:0] d;
        logic l;
        @(posedge clk);
        #1;
        out_rdy = 1'b0;
        q_data.delete();
        q_last.delete();
        acc_cnt   = 0;
        stall_acc = -1;
        fork
            begin
                send_frame(2'd2, 100, 2'd1, 8);
                send_frame(2'd1, 200, 2'd3, 8);
                send_frame(2'd0, 300, 2'd2, 8);
            end
            begin
                repeat (20) @(posedge clk);
                #1;
                out_rdy = 1'b1;
            end
        join
        wait_q(24);
        n_cmp++;
        if (stall_acc !== 16) begin
            n_err++;
            $display("FAIL b2b_stall_point: in_rdy first low after %0d beats, want 16", stall_acc);
        end
        for (int i = 0; i < 24 && q_data.size() > 0; i++) begin
            d = q_data.pop_front();
            l = q_last.pop_front();
            n_cmp++;
            if (d !== 32'(bases[i/8] + exp_tab[steps[i/8]][i%8])) begin
                n_err++;
                $display("FAIL b2b_data[%0d]: got %0d want %0d", i, d, bases[i/8] + exp_tab[steps[i/8]][i%8]);
            end
            n_cmp++;
            if (l !== (i % 8 == 7)) begin
                n_err++;
                $display("FAIL b2b_last[%0d]: got %0b want %0b", i, l, i % 8 == 7);
            end
        end
    endtask

    task automatic test_random_rdy();
        logic [1:0] steps [4] = '{2'd3, 2'd1, 2'd2, 2'd0};
        logic [1:0] alts [4]  = '{2'd2, 2'd0, 2'd3, 2'd1};
        int tab [4]           = '{0, 1, 2, 0};
        logic drv_done = 1'b0;
        logic [31:0] d;
        logic l;
        @(posedge clk);
        #1;
        q_data.delete();
        q_last.delete();
        fork
            begin
                for (int f = 0; f < 4; f++)
                    send_frame(steps[f], 400 + 100 * f, alts[f], 8);
                drv_done = 1'b1;
            end
            begin
                while (!drv_done) begin
                    @(posedge clk);
                    #1;
                    out_rdy = 1'($urandom_range(0, 1));
                end
            end
        join
        out_rdy = 1'b1;
        wait_q(32);
        for (int i = 0; i < 32 && q_data.size() > 0; i++) begin
            d = q_data.pop_front();
            l = q_last.pop_front();
            n_cmp++;
            if (d !== 32'(400 + 100 * (i / 8) + exp_tab[tab[i/8]][i%8])) begin
                n_err++;
                $display("FAIL rnd_data[%0d]: got %0d want %0d", i, d, 400 + 100 * (i / 8) + exp_tab[tab[i/8]][i%8]);
            end
            n_cmp++;
            if (l !== (i % 8 == 7)) begin
                n_err++;
                $display("FAIL rnd_last[%0d]: got %0b want %0b", i, l, i % 8 == 7);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] d;
        @(posedge clk);
        #1;
        out_rdy = 1'b0;
        q_data.delete();
        q_last.delete();
        send_frame(2'd0, 800, 2'd0, 8);
        send_frame(2'd0, 900, 2'd0, 5);
        #2;
        n_cmp++; if (out_vld !== 1'b1) begin n_err++; $display("FAIL pre_rst_out_vld: got %0b want 1", out_vld); end
        s_rst_n = 1'b0;
        #1;
        n_cmp++; if (out_vld !== 1'b0) begin n_err++; $display("FAIL mid_rst_out_vld: got %0b want 0", out_vld); end
        n_cmp++; if (in_rdy !== 1'b1) begin n_err++; $display("FAIL mid_rst_in_rdy: got %0b want 1", in_rdy); end
        n_cmp++; if (out_data !== 32'd0) begin n_err++; $display("FAIL mid_rst_out_data: got %0d want 0", out_data); end
        repeat (2) @(negedge clk);
        s_rst_n = 1'b1;
        @(posedge clk);
        #1;
        q_data.delete();
        q_last.delete();
        out_rdy = 1'b1;
        send_frame(2'd0, 0, 2'd0, 8);
        wait_q(8);
        repeat (10) @(negedge clk);
        n_cmp++;
        if (q_data.size() !== 8) begin
            n_err++;
            $display("FAIL post_rst_count: got %0d outputs want 8", q_data.size());
        end
        for (int a = 0; a < 8 && q_data.size() > 0; a++) begin
            d = q_data.pop_front();
            n_cmp++;
            if (d !== 32'(a)) begin
                n_err++;
                $display("FAIL post_rst_data[%0d]: got %0d want %0d", a, d, a);
            end
        end
    endtask

    initial begin
        test_reset();
        test_perm(0);
        test_perm(2);
        test_perm(1);
        test_back_to_back();
        test_random_rdy();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/common_lib_pseudo_uninvert_buf.md
# common_lib_pseudo_uninvert_buf

Streaming reorder buffer that undoes the pseudo-invert digit permutation. A frame of N = B^S samples arrives in pseudo-inverted order for a given step and leaves in natural index order. Two ping-pong banks allow one frame to be written while the previous one drains. It sits on the receive side of NTT/INTT stages that emit pseudo-inverted data.

## Interface
- S, 4, number of base-B digits per index (S >= 2)
- B, 2, digit base, power of 2, >= 2
- DATA_W, 32, sample width
- Derived: B_W = $clog2(B), S_W = $clog2(S), N = B^S, A_W = S*B_W
- clk  in  1  clock
- s_rst_n  in  1  reset; asynchronous, active-low
- in_data  in  DATA_W  input sample
- in_step  in  S_W  permutation step; sampled only on the first beat of a frame
- in_vld  in  1  input valid
- in_rdy  out  1  input ready
- out_data  out  DATA_W  output sample, natural order
- out_last  out  1  marks beat N-1 of a frame
- out_vld  out  1  output valid
- out_rdy  in  1  output ready

## Operation
- Index digits: k = sum k_j*B^j, j = 0..S-1.
- Forward map P_step, digit s: z_s = v_(S-1-s) if s < step, else v_(s-step). Step 0 is identity; step S-1 is full digit reversal.
- Inverse map Q_step, digit j: v_j = z_(j+step) if j < S-step, else z_(S-1-j).
- Input beat k of a frame (k = 0..N-1, counted on in_vld & in_rdy) is written to address Q_step(k) of the current write bank.
- Output reads addresses 0..N-1 of the read bank in order. out_last = 1 on address N-1.
- Step latch: taken from in_step on beat k = 0 and held for the frame. An in_step value >= S is latched as 0.
- Each bank has one of four states: EMPTY, FILLING, FULL, DRAINING.
  - EMPTY -> FILLING on the first write.
  - FILLING -> FULL on write N-1.
  - FULL -> DRAINING when that bank is the read bank and the read side is idle.
  - DRAINING -> EMPTY when output beat N-1 is accepted.
- wr_bank toggles after write N-1. rd_bank toggles after output beat N-1 is accepted.
- in_rdy = write bank is EMPTY or FILLING.
- Simultaneous events:
  - Write N-1 into one bank and the last read from the other bank in the same cycle are both legal.
  - A bank freed by the last read is writable the next cycle.
- Reset: both banks EMPTY, wr_bank = rd_bank = 0, counters = 0. Reset mid-frame discards all buffered data.

## Timing
- Reset values: in_rdy = 1, out_vld = 0, out_last = 0, out_data = 0.
- Bank RAM read latency is 1 cycle. A 2-entry output skid keeps reads flowing under out_rdy backpressure with no bubble.
- Latency: last input beat accepted at cycle t -> out_vld = 1 with address 0 at cycle t+2. With the macro below enabled, t+3.
- Throughput: one sample per cycle in and out. With both banks busy, input stalls (in_rdy = 0) until a bank returns to EMPTY.
- out_data and out_last are held stable while out_vld & !out_rdy.
- in_data is ignored when in_vld = 0.

## Configuration
- COMMON_LIB_PSEUDO_UNINVERT_BUF_OUT_REG_EN
  - Defined: adds a registered output slice after the skid (full valid/ready pipeline register). Latency becomes t+3; throughput is unchanged.
  - Undefined: outputs are driven directly from the skid, latency t+2.

## Test plan
- S=3, B=2, step=0, in_data = k for k = 0..7, out_rdy = 1 -> out_data 0,1,2,3,4,5,6,7; out_last only on the 8th beat; first out_vld two cycles after the last input.
- S=3, B=2, step=2, in_data = k -> out_data 0,4,2,6,1,5,3,7.
- S=3, B=2, step=1, in_data = k -> out_data 0,2,4,6,1,3,5,7.
- Three back-to-back frames with steps 2, 1, 0 and out_rdy = 0 for the first 20 cycles:
  - in_rdy drops after 16 accepted beats.
  - The sequences above appear in frame order with no loss after out_rdy = 1.
  - in_step changes mid-frame are ignored.
- Random out_rdy toggling at 50% over 4 frames -> no duplicated or dropped samples; data and out_last stable while stalled.
- s_rst_n asserted after 5 beats of a frame -> out_vld = 0 and in_rdy = 1 immediately. The next full frame with step=0 outputs 0..7 exactly.
